phy_tx_lane: RTL and testbench

- Single-lane PHY transmitter: the parallel-to-serial counterpart of the phy_rx deserializer.
- Accepts 8-bit bytes over a valid/ready handshake and serializes them MSB-first at clk_8f.
- Emits a startup train of COM symbols (0xBC) so the receiver can align, then fills idle symbol slots with COM.
- Sits between the byte-level link logic and the serial line feeding phy_rx (in_0/in_1 inputs); two instances form the two-lane tx.

---
 rtl/phy_tx_pkg.sv | 12 +
 rtl/phy_tx_ser8.sv | 40 ++++
 rtl/phy_tx_lane.sv | 123 ++++++++++++
 tb/tb_phy_tx_lane.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared constants and FSM encoding for the single-lane PHY transmitter.
package phy_tx_pkg;

    localparam logic [7:0] COM_SYM_DEF = 8'hBC;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_ACTIVE   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/phy_tx_ser8.sv
// 8-bit parallel-in serial-out shifter, MSB first, with symbol-boundary flag.
module phy_tx_ser8 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    output logic       serial_o,
    output logic       last_bit_o
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        sr_d      = {sr_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (clear_i) begin
            sr_d      = 8'h00;
            bit_cnt_d = 3'd0;
        end else if (load_i) begin
            sr_d      = load_data_i;
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign serial_o   = sr_q[7];
    assign last_bit_o = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/phy_tx_lane.sv
// Single-lane PHY transmitter: COM sync train, 1-entry holding register, MSB-first serializer.
module phy_tx_lane
    import phy_tx_pkg::*;
#(
    parameter int         SYNC_SYMS = 4,
    parameter logic [7:0] COM_SYM   = COM_SYM_DEF
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       serial_out,
    output logic       data_flag,
    output logic       sync_done
);

    localparam int              SCW       = $clog2(SYNC_SYMS + 1);
    localparam logic [SCW-1:0]  SYNC_LAST = SCW'(SYNC_SYMS);

    tx_state_e      state_q, state_d;
    logic [SCW-1:0] sync_cnt_q, sync_cnt_d;
    logic [7:0]     hold_data_q, hold_data_d;
    logic           hold_valid_q, hold_valid_d;
    logic           data_flag_q, data_flag_d;
    logic           sync_done_q, sync_done_d;

    logic       ser_load;
    logic       ser_clear;
    logic [7:0] ser_data;
    logic       last_bit;
    logic       accept;

    assign ready_out = (state_q != ST_DISABLED) && !hold_valid_q;
    assign accept    = valid_in && ready_out;
    assign data_flag = data_flag_q;
    assign sync_done = sync_done_q;

    phy_tx_ser8 u_ser (
        .clk_i       (clk_8f),
        .rst_i       (reset),
        .clear_i     (ser_clear),
        .load_i      (ser_load),
        .load_data_i (ser_data),
        .serial_o    (serial_out),
        .last_bit_o  (last_bit)
    );

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        data_flag_d  = data_flag_q;
        sync_done_d  = sync_done_q;
        ser_load     = 1'b0;
        ser_clear    = 1'b0;
        ser_data     = COM_SYM;
        case (state_q)
            ST_DISABLED: begin
                if (enable) begin
                    ser_load   = 1'b1;
                    sync_cnt_d = SCW'(1);
                    state_d    = ST_SYNC;
                end
            end
            ST_SYNC, ST_ACTIVE: begin
                if (!enable) begin
                    // Disable truncates the symbol in flight and drops any pending byte.
                    state_d      = ST_DISABLED;
                    ser_clear    = 1'b1;
                    sync_cnt_d   = '0;
                    hold_valid_d = 1'b0;
                    data_flag_d  = 1'b0;
                    sync_done_d  = 1'b0;
                end else begin
                    if (accept) begin
                        hold_data_d  = data_in;
                        hold_valid_d = 1'b1;
                    end
                    if (last_bit) begin
                        ser_load = 1'b1;
                        if (state_q == ST_SYNC && sync_cnt_q < SYNC_LAST) begin
                            sync_cnt_d = sync_cnt_q + 1'b1;
                        end else begin
                            // A byte accepted on this same edge waits for the next slot.
                            state_d     = ST_ACTIVE;
                            sync_done_d = 1'b1;
                            if (hold_valid_q) begin
                                ser_data     = hold_data_q;
                                hold_valid_d = 1'b0;
                                data_flag_d  = 1'b1;
                            end else begin
                                data_flag_d  = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_DISABLED;
        endcase
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q      <= ST_DISABLED;
            sync_cnt_q   <= '0;
            hold_data_q  <= 8'h00;
            hold_valid_q <= 1'b0;
            data_flag_q  <= 1'b0;
            sync_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            data_flag_q  <= data_flag_d;
            sync_done_q  <= sync_done_d;
        end
    end

endmodule

// File: tb/tb_phy_tx_lane.sv
// Self-checking bench for phy_tx_lane against a symbol-slot level reference model.
module tb_phy_tx_lane;

    localparam int         SYNC_SYMS = 4;
    localparam logic [7:0] COM       = 8'hBC;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       serial_out;
    logic       data_flag;
    logic       sync_done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_8f = ~clk_8f;

    phy_tx_lane #(.SYNC_SYMS(SYNC_SYMS), .COM_SYM(COM)) dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .serial_out (serial_out),
        .data_flag  (data_flag),
        .sync_done  (sync_done)
    );

    // Reference model: tracks which symbol occupies the current 8-cycle slot
    // and a byte queue of depth one; position within a slot is cycles mod 8.
    bit         m_en;
    int         m_cyc;
    logic [7:0] m_sym;
    logic [7:0] m_q[$];
    bit         m_flag;
    bit         m_sdone;
    int         m_nsym;

    always @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            m_en = 0; m_cyc = 0; m_sym = 8'h00; m_q.delete();
            m_flag = 0; m_sdone = 0; m_nsym = 0;
        end else if (!m_en) begin
            if (enable) begin
                m_en = 1; m_cyc = 0; m_sym = COM; m_nsym = 0;
            end
        end else if (!enable) begin
            m_en = 0; m_cyc = 0; m_sym = 8'h00; m_q.delete();
            m_flag = 0; m_sdone = 0; m_nsym = 0;
        end else begin
            bit had_byte;
            had_byte = (m_q.size() != 0);
            if (m_cyc % 8 == 7) begin
                m_nsym++;
                if (!m_sdone && m_nsym < SYNC_SYMS) begin
                    m_sym = COM;
                end else begin
                    m_sdone = 1;
                    if (had_byte) begin
                        m_sym = m_q.pop_front();
                        m_flag = 1;
                    end else begin
                        m_sym = COM;
                        m_flag = 0;
                    end
                end
            end
            m_cyc++;
            if (valid_in && !had_byte) m_q.push_back(data_in);
        end
    end

    function automatic logic m_ready();
        return m_en && (m_q.size() == 0);
    endfunction

    function automatic logic [3:0] m_exp();
        logic s;
        s = m_en ? m_sym[7 - (m_cyc % 8)] : 1'b0;
        return {s, m_ready(), m_flag, m_sdone};
    endfunction

    task automatic step();
        @(posedge clk_8f);
        @(negedge clk_8f);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc=%0d: got %b expected 0000", i,
                         {serial_out, ready_out, data_flag, sync_done});
            end
        end
    endtask

    task automatic test_sync();
        logic [7:0] first;
        do_reset();
        enable = 1'b1;
        first = 8'h00;
        for (int k = 0; k < 40; k++) begin
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL sync_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
            if (k < 8) first[7-k] = serial_out;
            if (k == 31 || k == 32) begin
                tests_run++;
                if (sync_done !== (k == 32)) begin
                    tests_failed++;
                    $display("FAIL sync_done_timing k=%0d: got %b expected %b", k, sync_done, (k == 32));
                end
            end
        end
        tests_run++;
        if (first !== 8'hBC) begin
            tests_failed++;
            $display("FAIL first_com_bits: got %h expected bc", first);
        end
    endtask

    task automatic test_sync_data();
        logic [7:0] cap;
        int nflag;
        do_reset();
        enable = 1'b1; valid_in = 1'b1; data_in = 8'hA5;
        cap = 8'h00; nflag = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL sync_data_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
            if (k <= 1) begin
                tests_run++;
                if (ready_out !== (k == 0)) begin
                    tests_failed++;
                    $display("FAIL sync_accept_ready k=%0d: got %b expected %b", k, ready_out, (k == 0));
                end
            end
            if (k == 1) valid_in = 1'b0;
            if (data_flag === 1'b1) begin
                if (nflag < 8) cap[7-nflag] = serial_out;
                nflag++;
            end
        end
        tests_run++;
        if (cap !== 8'hA5 || nflag != 8) begin
            tests_failed++;
            $display("FAIL sync_data_byte: got %h over %0d flagged cycles expected a5 over 8", cap, nflag);
        end
    endtask

    task automatic test_stream();
        logic [7:0] bytes [3];
        logic [23:0] cap;
        int idx, nbits, first, last;
        logic rdy_prev;
        bytes[0] = 8'h0F; bytes[1] = 8'hF0; bytes[2] = 8'h3C;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 33; k++) begin
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL stream_sync_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
        end
        idx = 0; nbits = 0; first = -1; last = -1; cap = '0;
        valid_in = 1'b1; data_in = bytes[0];
        for (int k = 0; k < 64; k++) begin
            rdy_prev = m_ready();
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL stream_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
            if (valid_in && rdy_prev) begin
                idx++;
                if (idx < 3) data_in = bytes[idx];
                else valid_in = 1'b0;
            end
            if (data_flag === 1'b1) begin
                if (nbits < 24) cap[23-nbits] = serial_out;
                nbits++;
                if (first < 0) first = k;
                last = k;
            end
        end
        tests_run++;
        if (cap !== 24'h0FF03C || nbits != 24 || (last - first) != 23) begin
            tests_failed++;
            $display("FAIL stream_bits: got %h bits=%0d span=%0d expected 0ff03c bits=24 span=23",
                     cap, nbits, last - first);
        end
    endtask

    task automatic test_disable();
        int flagcnt;
        bit reached;
        logic rdy_prev;
        logic [7:0] cap;
        int nflag;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 33; k++) step();
        valid_in = 1'b1; data_in = 8'h55;
        flagcnt = 0; reached = 0;
        for (int k = 0; k < 40 && !reached; k++) begin
            rdy_prev = m_ready();
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL disable_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
            if (valid_in && rdy_prev) begin
                if (data_in == 8'h55) data_in = 8'hAA;
                else valid_in = 1'b0;
            end
            if (data_flag === 1'b1) flagcnt++;
            if (flagcnt == 4) reached = 1;
        end
        tests_run++;
        if (!reached || ready_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL disable_setup: got reached=%0d ready=%b expected reached=1 ready=0", reached, ready_out);
        end
        enable = 1'b0; valid_in = 1'b0;
        step();
        tests_run++;
        if ({serial_out, ready_out, sync_done, data_flag} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL disable_immediate: got %b expected 0000",
                     {serial_out, ready_out, sync_done, data_flag});
        end
        enable = 1'b1;
        nflag = 0; cap = 8'h00;
        for (int k = 0; k < 48; k++) begin
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL reenable_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
            if (data_flag === 1'b1) nflag++;
            if (k >= 40) cap[7-(k-40)] = serial_out;
        end
        tests_run++;
        if (nflag != 0 || cap !== 8'hBC || sync_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL reenable_idle: got flags=%0d sym=%h sync_done=%b expected 0 bc 1", nflag, cap, sync_done);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 12; k++) step();
        #2;
        reset = 1'b1; enable = 1'b0;
        #1;
        tests_run++;
        if ({serial_out, ready_out, data_flag, sync_done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset_immediate: got %b expected 0000",
                     {serial_out, ready_out, data_flag, sync_done});
        end
        step();
        reset = 1'b0; enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL async_retrain_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
            if (k == 31 || k == 32) begin
                tests_run++;
                if (sync_done !== (k == 32)) begin
                    tests_failed++;
                    $display("FAIL async_retrain_sync_done k=%0d: got %b expected %b", k, sync_done, (k == 32));
                end
            end
        end
    endtask

    task automatic test_random();
        logic rdy_prev;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rdy_prev = m_ready();
            step();
            tests_run++;
            if ({serial_out, ready_out, data_flag, sync_done} !== m_exp()) begin
                tests_failed++;
                $display("FAIL random_model k=%0d: got %b expected %b", k,
                         {serial_out, ready_out, data_flag, sync_done}, m_exp());
            end
            if (!valid_in || rdy_prev) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = 8'($urandom);
            end
            if (enable) begin
                if ($urandom_range(0, 299) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                enable = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        test_reset();
        test_sync();
        test_sync_data();
        test_stream();
        test_disable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
